// File: rtl/virtual_input_pkg.sv
// +----------------------------------------------------------------------------+
// | virtual_input_pkg : shared constants and parser state type for the virtual |
// | input command receiver.                                     Revision: 1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none

package virtual_input_pkg;

   localparam logic [7:0] CHAR_T    = 8'h54;
   localparam logic [7:0] CHAR_R    = 8'h52;
   localparam logic [7:0] CHAR_T_LC = 8'h74;
   localparam logic [7:0] CHAR_R_LC = 8'h72;
   localparam logic [7:0] CHAR_CR   = 8'h0D;
   localparam logic [7:0] CHAR_LF   = 8'h0A;
   localparam logic [7:0] CHAR_0    = 8'h30;
   localparam logic [7:0] CHAR_9    = 8'h39;

   localparam logic [4:0] IDX_RESET_ALL = 5'd31;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_T_D1,
      ST_T_D0,
      ST_T_CR,
      ST_R_CR,
      ST_SETUP,
      ST_PULSE,
      ST_GUARD
   } parser_state_e;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= CHAR_0) && (c <= CHAR_9);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_8n1.sv
// +----------------------------------------------------------------------------+
// | uart_rx_8n1 : 8N1 UART receiver with 2-FF input synchronizer, start-bit    |
// | glitch rejection and stop-bit framing check.                Revision: 1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx_8n1 #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   rx_state_e     state_q, state_d;
   logic [2:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          line;

   // sync_q[1] is the synchronized line, sync_q[2] its previous value
   assign line = sync_q[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RX_IDLE;
         sync_q  <= 3'b111;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sync_d  = {sync_q[1:0], rx};
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (sync_q[2] && !line) begin
               state_d = RX_START;
               cnt_d   = '0;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = line ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {line, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = RX_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL_M1) begin
               state_d = RX_IDLE;
               valid_d = line;
               ferr_d  = !line;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign data       = shift_q;
   assign byte_valid = valid_q;
   assign frame_err  = ferr_q;

endmodule

`default_nettype wire

// File: rtl/virtual_input_cmd_rx.sv
// +----------------------------------------------------------------------------+
// | virtual_input_cmd_rx : decodes "Tdd<CR>" / "R<CR>" UART commands into a   |
// | target index and a spaced control strobe.                   Revision: 1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none

module virtual_input_cmd_rx
   import virtual_input_pkg::*;
#(
   parameter int CLK_HZ      = 50000000,
   parameter int BAUD        = 115200,
   parameter int PULSE_LEN   = 4,
   parameter int NUM_TARGETS = 22
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rx,
   output logic [4:0] number,
   output logic       control,
   output logic       busy,
   output logic       cmd_ok,
   output logic       cmd_err
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [PW-1:0] PULSE_M1 = PW'(PULSE_LEN - 1);
   localparam logic [6:0] NUM_T7 = 7'(NUM_TARGETS);

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ferr;

   uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rx        (uart_rx),
      .data      (rx_data),
      .byte_valid(rx_valid),
      .frame_err (rx_ferr)
   );

   parser_state_e state_q, state_d;
   logic [3:0]    d1_q, d1_d, d0_q, d0_d;
   logic [4:0]    number_q, number_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          control_q, control_d;
   logic          ok_q, ok_d, err_q, err_d;
   logic [6:0]    idx;
   logic          is_t, is_r, is_cr;

   // Range check happens on the full 7-bit value so 32..99 cannot alias
   assign idx   = 7'(d1_q) * 7'd10 + 7'(d0_q);
   assign is_t  = (rx_data == CHAR_T) || (rx_data == CHAR_T_LC);
   assign is_r  = (rx_data == CHAR_R) || (rx_data == CHAR_R_LC);
   assign is_cr = (rx_data == CHAR_CR);
   assign busy  = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_GUARD);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         d1_q      <= '0;
         d0_q      <= '0;
         number_q  <= IDX_RESET_ALL;
         pcnt_q    <= '0;
         control_q <= 1'b0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         d1_q      <= d1_d;
         d0_q      <= d0_d;
         number_q  <= number_d;
         pcnt_q    <= pcnt_d;
         control_q <= control_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      d1_d     = d1_q;
      d0_d     = d0_q;
      number_d = number_q;
      pcnt_d   = pcnt_q;
      ok_d     = 1'b0;
      err_d    = rx_ferr || (rx_valid && busy);
      case (state_q)
         ST_IDLE: if (rx_valid) begin
            if (is_t)                                      state_d = ST_T_D1;
            else if (is_r)                                 state_d = ST_R_CR;
            else if (!is_cr && (rx_data != CHAR_LF))       err_d   = 1'b1;
         end
         ST_T_D1: if (rx_valid) begin
            if (is_digit(rx_data)) begin
               d1_d    = rx_data[3:0];
               state_d = ST_T_D0;
            end else begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_T_D0: if (rx_valid) begin
            if (is_digit(rx_data)) begin
               d0_d    = rx_data[3:0];
               state_d = ST_T_CR;
            end else begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_T_CR: if (rx_valid) begin
            if (is_cr && (idx < NUM_T7)) begin
               number_d = idx[4:0];
               ok_d     = 1'b1;
               state_d  = ST_SETUP;
            end else begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_R_CR: if (rx_valid) begin
            if (is_cr) begin
               number_d = IDX_RESET_ALL;
               ok_d     = 1'b1;
               state_d  = ST_SETUP;
            end else begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            pcnt_d  = '0;
            state_d = ST_PULSE;
         end
         ST_PULSE, ST_GUARD: begin
            if (pcnt_q == PULSE_M1) begin
               pcnt_d  = '0;
               state_d = (state_q == ST_PULSE) ? ST_GUARD : ST_IDLE;
            end else begin
               pcnt_d = pcnt_q + PW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      control_d = (state_d == ST_PULSE);
   end

   assign number  = number_q;
   assign control = control_q;
   assign cmd_ok  = ok_q;
   assign cmd_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_virtual_input_cmd_rx.sv
// +----------------------------------------------------------------------------+
// | tb_virtual_input_cmd_rx : self-checking bench for virtual_input_cmd_rx.    |
// |                                                             Revision: 1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_virtual_input_cmd_rx;
   import virtual_input_pkg::*;

   localparam int CLK_HZ = 50000000;
   localparam int BAUD   = 3125000;
   localparam int CPB    = CLK_HZ / BAUD;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx_a = 1'b1, rx_b = 1'b1;
   logic [4:0] num_a, num_b;
   logic ctl_a, ctl_b, busy_a, busy_b, ok_a, ok_b, err_a, err_b;

   virtual_input_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PULSE_LEN(4), .NUM_TARGETS(22)) dut (
      .clk(clk), .reset(reset), .uart_rx(rx_a), .number(num_a), .control(ctl_a),
      .busy(busy_a), .cmd_ok(ok_a), .cmd_err(err_a));

   // Long pulse so that back-to-back bytes land while busy
   virtual_input_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PULSE_LEN(400), .NUM_TARGETS(22)) dut_b (
      .clk(clk), .reset(reset), .uart_rx(rx_b), .number(num_b), .control(ctl_b),
      .busy(busy_b), .cmd_ok(ok_b), .cmd_err(err_b));

   always #5 clk = ~clk;

   int n_cmp = 0, n_fail = 0;
   int a_ok = 0, a_err = 0, a_rise = 0, b_ok = 0, b_err = 0, b_rise = 0, viol = 0;
   logic ctl_a_prev = 1'b0, ctl_b_prev = 1'b0;
   logic [4:0] num_a_prev = 5'd0;

   always @(negedge clk) begin
      ctl_a_prev <= ctl_a;
      ctl_b_prev <= ctl_b;
      num_a_prev <= num_a;
      if (ctl_a && !ctl_a_prev) a_rise <= a_rise + 1;
      if (ctl_b && !ctl_b_prev) b_rise <= b_rise + 1;
      if (ok_a)  a_ok  <= a_ok + 1;
      if (err_a) a_err <= a_err + 1;
      if (ok_b)  b_ok  <= b_ok + 1;
      if (err_b) b_err <= b_err + 1;
      if ((ok_a && err_a) || (ok_b && err_b) || (ctl_a && ctl_a_prev && num_a != num_a_prev))
         viol <= viol + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: command grammar evaluated on a buffer of accepted bytes
   logic [7:0] m_pend[$];
   int m_ok = 0, m_err = 0, m_rise = 0, m_num = 31;

   task automatic model_issue(input int idx);
      m_num = idx; m_ok++; m_rise++;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] u;
      int idx;
      u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
      if (m_pend.size() == 0) begin
         if (u == CHAR_T || u == CHAR_R) m_pend.push_back(u);
         else if (b != CHAR_CR && b != CHAR_LF) m_err++;
      end else if (m_pend[0] == CHAR_R) begin
         if (b == CHAR_CR) model_issue(31); else m_err++;
         m_pend.delete();
      end else if (m_pend.size() < 3) begin
         if (b >= CHAR_0 && b <= CHAR_9) m_pend.push_back(b);
         else begin m_err++; m_pend.delete(); end
      end else begin
         idx = (int'(m_pend[1]) - 48) * 10 + (int'(m_pend[2]) - 48);
         if (b == CHAR_CR && idx < 22) model_issue(idx); else m_err++;
         m_pend.delete();
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit on_b, input bit stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (on_b) rx_b = frame[i]; else rx_a = frame[i];
         repeat (CPB) @(negedge clk);
      end
      if (on_b) rx_b = 1'b1; else rx_a = 1'b1;
   endtask

   task automatic send_a(input logic [7:0] b);
      send_byte(b, 1'b0, 1'b1);
      model_byte(b);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_a(s[i]);
   endtask

   typedef struct {
      string      cmd;
      int         ok;
      int         err;
      int         rise;
      logic [4:0] num;
   } vec_t;

   function automatic vec_t mk(input string c, input int o, input int e, input int r, input int n);
      vec_t v;
      v.cmd = c; v.ok = o; v.err = e; v.rise = r; v.num = 5'(n);
      return v;
   endfunction

   vec_t vecs[13];
   int s_ok, s_err, s_rise, sm_ok, sm_err, sm_rise;

   task automatic snap();
      s_ok = a_ok; s_err = a_err; s_rise = a_rise;
      sm_ok = m_ok; sm_err = m_err; sm_rise = m_rise;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int hi_cnt, first_hi, busy_low;
      vecs[0]  = mk("t21\015",        1, 0, 1, 21);
      vecs[1]  = mk("T22\015",        0, 1, 0, 21);
      vecs[2]  = mk("R\015",          1, 0, 1, 31);
      vecs[3]  = mk("TX5\015",        0, 2, 0, 31);
      vecs[4]  = mk("T03\015",        1, 0, 1, 3);
      vecs[5]  = mk("\012\015T17\015", 1, 0, 1, 17);
      vecs[6]  = mk("TT12\015",       0, 3, 0, 17);
      vecs[7]  = mk("T9\015",         0, 1, 0, 17);
      vecs[8]  = mk("R5",             0, 1, 0, 17);
      vecs[9]  = mk("T00\015",        1, 0, 1, 0);
      vecs[10] = mk("r\015",          1, 0, 1, 31);
      vecs[11] = mk("T99\015",        0, 1, 0, 31);
      vecs[12] = mk("T123\015",       0, 1, 0, 31);

      repeat (3) @(negedge clk);
      chk("reset number", int'(num_a), 31);
      chk("reset control", int'(ctl_a), 0);
      chk("reset busy", int'(busy_a), 0);
      chk("reset cmd_ok", int'(ok_a), 0);
      chk("reset cmd_err", int'(err_a), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Cycle-exact timing of "T05<CR>"
      send_str("T05");
      found = 1'b0; hi_cnt = 0; first_hi = -1; busy_low = -1;
      fork
         send_a(CHAR_CR);
         begin
            for (int i = 0; i < 400; i++) begin
               @(negedge clk);
               if (dut.rx_valid) begin found = 1'b1; break; end
            end
            chk("T05 byte_valid seen", int'(found), 1);
            @(negedge clk);
            chk("T05 number", int'(num_a), 5);
            chk("T05 cmd_ok", int'(ok_a), 1);
            chk("T05 control before pulse", int'(ctl_a), 0);
            for (int j = 1; j <= 14; j++) begin
               @(negedge clk);
               if (ctl_a) begin hi_cnt++; if (first_hi < 0) first_hi = j; end
               if (!busy_a && busy_low < 0) busy_low = j;
            end
            chk("T05 control rise delay", first_hi, 1);
            chk("T05 control high cycles", hi_cnt, 4);
            chk("T05 busy low delay", busy_low, 9);
         end
      join
      repeat (30) @(negedge clk);

      foreach (vecs[k]) begin
         snap();
         send_str(vecs[k].cmd);
         repeat (30) @(negedge clk);
         chk($sformatf("vec%0d cmd_ok", k), a_ok - s_ok, vecs[k].ok);
         chk($sformatf("vec%0d cmd_err", k), a_err - s_err, vecs[k].err);
         chk($sformatf("vec%0d rises", k), a_rise - s_rise, vecs[k].rise);
         chk($sformatf("vec%0d number", k), int'(num_a), int'(vecs[k].num));
      end

      // Framing error, then a start glitch
      snap();
      send_byte(8'h41, 1'b0, 1'b0);
      repeat (CPB + 30) @(negedge clk);
      chk("frame err count", a_err - s_err, 1);
      chk("frame no rise", a_rise - s_rise, 0);
      snap();
      rx_a = 1'b0; repeat (3) @(negedge clk); rx_a = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch no err", a_err - s_err, 0);
      send_str("T03\015");
      repeat (30) @(negedge clk);
      chk("after frame err number", int'(num_a), 3);

      // Bytes arriving while busy on the long-pulse instance
      s_ok = b_ok; s_err = b_err; s_rise = b_rise;
      send_byte(CHAR_T, 1'b1, 1'b1); send_byte(8'h30, 1'b1, 1'b1);
      send_byte(8'h37, 1'b1, 1'b1); send_byte(CHAR_CR, 1'b1, 1'b1);
      send_byte(CHAR_T, 1'b1, 1'b1); send_byte(8'h30, 1'b1, 1'b1);
      send_byte(8'h38, 1'b1, 1'b1); send_byte(CHAR_CR, 1'b1, 1'b1);
      repeat (900) @(negedge clk);
      chk("busy cmd_ok", b_ok - s_ok, 1);
      chk("busy cmd_err", b_err - s_err, 4);
      chk("busy rises", b_rise - s_rise, 1);
      chk("busy number", int'(num_b), 7);

      // Reset in the second pulse cycle
      snap();
      fork
         send_str("T12\015");
         begin
            found = 1'b0;
            for (int i = 0; i < 800; i++) begin
               @(negedge clk);
               if (ctl_a) begin found = 1'b1; break; end
            end
            chk("rst-pulse control seen", int'(found), 1);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            chk("rst-pulse control", int'(ctl_a), 0);
            chk("rst-pulse number", int'(num_a), 31);
            reset = 1'b0;
         end
      join
      m_num = 31;
      repeat (40) @(negedge clk);
      chk("rst-pulse single rise", a_rise - s_rise, 1);
      chk("rst-pulse number held", int'(num_a), 31);
      send_str("T15\015");
      repeat (30) @(negedge clk);
      chk("after reset number", int'(num_a), 15);

      // Randomized bursts against the model
      for (int n = 0; n < 30; n++) begin
         int kind;
         string s;
         snap();
         kind = $urandom_range(0, 3);
         case (kind)
            0: s = $sformatf("%s%02d%c", ($urandom_range(0, 1) != 0) ? "T" : "t", $urandom_range(0, 21), 8'h0D);
            1: s = $sformatf("T%02d%c", $urandom_range(0, 99), 8'h0D);
            2: s = $sformatf("%s%c", ($urandom_range(0, 1) != 0) ? "R" : "r", 8'h0D);
            default: s = "";
         endcase
         if (kind == 3) begin
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
               logic [7:0] rb;
               case ($urandom_range(0, 4))
                  0: rb = CHAR_T;
                  1: rb = CHAR_R_LC;
                  2: rb = 8'(8'h30 + $urandom_range(0, 9));
                  3: rb = CHAR_CR;
                  default: rb = 8'($urandom_range(0, 255));
               endcase
               send_a(rb);
            end
         end else begin
            send_str(s);
         end
         repeat (30) @(negedge clk);
         chk($sformatf("rand%0d cmd_ok", n), a_ok - s_ok, m_ok - sm_ok);
         chk($sformatf("rand%0d cmd_err", n), a_err - s_err, m_err - sm_err);
         chk($sformatf("rand%0d rises", n), a_rise - s_rise, m_rise - sm_rise);
         chk($sformatf("rand%0d number", n), int'(num_a), m_num);
      end

      chk("ok/err overlap or number change while high", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
